// File: rtl/spi_slave_pkg.sv
// Shared types and defaults for the SPI mode-0 target endpoint.
package spi_slave_pkg;
    localparam int DATA_W_DEF      = 16;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        WAIT_CS = 2'd2
    } spi_slv_state_t;
endpackage

// File: rtl/spi_slave_sync_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer for one asynchronous pin plus
// registered-history rise/fall strobes, all in the clk domain.
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2,
    parameter bit RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Reset to the pin's idle level so leaving reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall = ~sync_q[SYNC_STAGES-1] & prev_q;
endmodule

// File: rtl/spi_slave_sync.sv
// SPI mode-0 target, MSB first, DATA_W-bit frames, pins oversampled in clk.
// Optional loopback port when SPI_SLAVE_LOOPBACK_EN is defined.
module spi_slave_sync
    import spi_slave_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sclk,
    input  logic              cs_bar,
    input  logic              mosi,
    output logic              miso,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_pending,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
`ifdef SPI_SLAVE_LOOPBACK_EN
    output logic              frame_err,
    input  logic              loopback
`else
    output logic              frame_err
`endif
);
    localparam int              CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic mosi_s;
    logic lb_sel;

    spi_slv_state_t    state;
    logic [DATA_W-1:0] rx_shift, tx_shift, hold;
    logic [CNT_W-1:0]  bit_cnt;
    logic              rx_done;

`ifdef SPI_SLAVE_LOOPBACK_EN
    assign lb_sel = loopback;
`else
    assign lb_sel = 1'b0;
`endif

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clk(clk), .reset(reset), .din(sclk), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
        .clk(clk), .reset(reset), .din(cs_bar), .rise(cs_rise), .fall(cs_fall)
    );

    // mosi shares the sclk sync depth so it lines up with the rise strobe.
    always_ff @(posedge clk) begin
        if (!reset) mosi_q <= '0;
        else        mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
    end
    assign mosi_s = mosi_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            rx_shift   <= '0;
            tx_shift   <= '0;
            hold       <= '0;
            bit_cnt    <= '0;
            rx_done    <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            tx_pending <= 1'b0;
            miso       <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            rx_done   <= 1'b0;
            if (rx_done) begin
                rx_data  <= rx_shift;
                rx_valid <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state   <= SHIFT;
                        bit_cnt <= '0;
                        if (lb_sel) begin
                            tx_shift <= rx_data;
                        end else begin
                            tx_shift   <= tx_pending ? hold : '0;
                            tx_pending <= 1'b0;
                        end
                    end
                end
                SHIFT: begin
                    // A deselect beats any sclk edge seen in the same cycle.
                    if (cs_rise) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                    end else if (sclk_rise) begin
                        rx_shift <= {rx_shift[DATA_W-2:0], mosi_s};
                        bit_cnt  <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            rx_done <= 1'b1;
                            state   <= WAIT_CS;
                        end
                    end else if (sclk_fall) begin
                        tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                    end
                end
                WAIT_CS: begin
                    if (cs_rise) state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            miso <= (state == SHIFT) && tx_shift[DATA_W-1];

            // Placed last so a load colliding with frame start keeps the new word pending.
            if (tx_load) begin
                hold       <= tx_data;
                tx_pending <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_spi_slave_sync.sv
// Directed bench for spi_slave_sync: a mode-0 master model plus pulse counters.
module tb_spi_slave_sync;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sclk = 1'b0;
    logic        cs_bar = 1'b1;
    logic        mosi = 1'b0;
    logic        miso;
    logic [15:0] tx_data = '0;
    logic        tx_load = 1'b0;
    logic        tx_pending;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        frame_err;
`ifdef SPI_SLAVE_LOOPBACK_EN
    logic        loopback = 1'b0;
`endif

    int tests = 0;
    int fails = 0;
    int rv_cnt = 0;
    int fe_cnt = 0;

    spi_slave_sync #(.DATA_W(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .sclk(sclk), .cs_bar(cs_bar), .mosi(mosi),
        .miso(miso), .tx_data(tx_data), .tx_load(tx_load), .tx_pending(tx_pending),
        .rx_data(rx_data), .rx_valid(rx_valid),
`ifdef SPI_SLAVE_LOOPBACK_EN
        .frame_err(frame_err), .loopback(loopback)
`else
        .frame_err(frame_err)
`endif
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid === 1'b1)  rv_cnt++;
        if (frame_err === 1'b1) fe_cnt++;
    end

    task automatic load_word(input logic [15:0] w);
        @(negedge clk);
        tx_data = w;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
    endtask

    // Master: coll asserts tx_load in the cycle the target starts the frame.
    task automatic spi_xfer(input logic [15:0] mw, input int nbits, input int half,
                            input bit raise_cs, input bit coll, input logic [15:0] cw,
                            output logic [15:0] sr);
        sr = '0;
        @(negedge clk);
        cs_bar = 1'b0;
        repeat (2) @(negedge clk);
        if (coll) begin
            tx_data = cw;
            tx_load = 1'b1;
            @(negedge clk);
            tx_load = 1'b0;
            repeat (3) @(negedge clk);
        end else begin
            repeat (4) @(negedge clk);
        end
        for (int i = 0; i < nbits; i++) begin
            mosi = mw[15-i];
            repeat (half) @(negedge clk);
            sr = {sr[14:0], miso};
            sclk = 1'b1;
            repeat (half) @(negedge clk);
            sclk = 1'b0;
        end
        mosi = 1'b0;
        repeat (half) @(negedge clk);
        if (raise_cs) begin
            cs_bar = 1'b1;
            repeat (8) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            sclk = ~sclk; cs_bar = ~cs_bar; mosi = ~mosi;
        end
        sclk = 1'b0; cs_bar = 1'b1; mosi = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (miso !== 1'b0) begin fails++; $display("FAIL reset_miso got %b exp 0", miso); end
        tests++; if (rx_data !== 16'h0000) begin fails++; $display("FAIL reset_rx_data got %h exp 0000", rx_data); end
        tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL reset_rx_valid got %b exp 0", rx_valid); end
        tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_frame_err got %b exp 0", frame_err); end
        tests++; if (tx_pending !== 1'b0) begin fails++; $display("FAIL reset_tx_pending got %b exp 0", tx_pending); end
        reset = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic();
        logic [15:0] sr;
        int rv0;
        load_word(16'hA55A);
        tests++; if (tx_pending !== 1'b1) begin fails++; $display("FAIL basic_pending_set got %b exp 1", tx_pending); end
        rv0 = rv_cnt;
        spi_xfer(16'h55AA, 16, 4, 1'b1, 1'b0, 16'h0, sr);
        tests++; if (rx_data !== 16'h55AA) begin fails++; $display("FAIL basic_rx got %h exp 55AA", rx_data); end
        tests++; if (rv_cnt - rv0 !== 1) begin fails++; $display("FAIL basic_rx_valid_pulses got %0d exp 1", rv_cnt - rv0); end
        tests++; if (sr !== 16'hA55A) begin fails++; $display("FAIL basic_miso got %h exp A55A", sr); end
        tests++; if (tx_pending !== 1'b0) begin fails++; $display("FAIL basic_pending_clr got %b exp 0", tx_pending); end
    endtask

    task automatic test_no_load();
        logic [15:0] sr;
        int rv0;
        rv0 = rv_cnt;
        spi_xfer(16'h1234, 16, 4, 1'b1, 1'b0, 16'h0, sr);
        tests++; if (sr !== 16'h0000) begin fails++; $display("FAIL noload_miso got %h exp 0000", sr); end
        tests++; if (rx_data !== 16'h1234) begin fails++; $display("FAIL noload_rx got %h exp 1234", rx_data); end
        tests++; if (rv_cnt - rv0 !== 1) begin fails++; $display("FAIL noload_rx_valid_pulses got %0d exp 1", rv_cnt - rv0); end
    endtask

    task automatic test_frame_err();
        logic [15:0] sr;
        int rv0, fe0;
        rv0 = rv_cnt; fe0 = fe_cnt;
        spi_xfer(16'hFFFF, 7, 4, 1'b1, 1'b0, 16'h0, sr);
        tests++; if (fe_cnt - fe0 !== 1) begin fails++; $display("FAIL ferr_pulses got %0d exp 1", fe_cnt - fe0); end
        tests++; if (rv_cnt - rv0 !== 0) begin fails++; $display("FAIL ferr_rx_valid got %0d exp 0", rv_cnt - rv0); end
        tests++; if (rx_data !== 16'h1234) begin fails++; $display("FAIL ferr_rx_kept got %h exp 1234", rx_data); end
        rv0 = rv_cnt; fe0 = fe_cnt;
        spi_xfer(16'hBEEF, 16, 4, 1'b1, 1'b0, 16'h0, sr);
        tests++; if (rx_data !== 16'hBEEF) begin fails++; $display("FAIL ferr_next_rx got %h exp BEEF", rx_data); end
        tests++; if (rv_cnt - rv0 !== 1) begin fails++; $display("FAIL ferr_next_rx_valid got %0d exp 1", rv_cnt - rv0); end
        tests++; if (fe_cnt - fe0 !== 0) begin fails++; $display("FAIL ferr_next_no_err got %0d exp 0", fe_cnt - fe0); end
    endtask

    task automatic test_load_collision();
        logic [15:0] sr;
        load_word(16'h1111);
        spi_xfer(16'h0000, 16, 4, 1'b1, 1'b1, 16'h2222, sr);
        tests++; if (sr !== 16'h1111) begin fails++; $display("FAIL coll_old_word got %h exp 1111", sr); end
        tests++; if (tx_pending !== 1'b1) begin fails++; $display("FAIL coll_pending got %b exp 1", tx_pending); end
        spi_xfer(16'h0000, 16, 4, 1'b1, 1'b0, 16'h0, sr);
        tests++; if (sr !== 16'h2222) begin fails++; $display("FAIL coll_new_word got %h exp 2222", sr); end
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] sr;
        int rv0, fe0;
        rv0 = rv_cnt; fe0 = fe_cnt;
        spi_xfer(16'hAAAA, 9, 4, 1'b0, 1'b0, 16'h0, sr);
        reset = 1'b0;
        cs_bar = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        tests++; if (fe_cnt - fe0 !== 0) begin fails++; $display("FAIL rstmid_frame_err got %0d exp 0", fe_cnt - fe0); end
        tests++; if (rv_cnt - rv0 !== 0) begin fails++; $display("FAIL rstmid_rx_valid got %0d exp 0", rv_cnt - rv0); end
        tests++; if (rx_data !== 16'h0000) begin fails++; $display("FAIL rstmid_rx_data got %h exp 0000", rx_data); end
        load_word(16'hC3C3);
        spi_xfer(16'h3C3C, 16, 16, 1'b1, 1'b0, 16'h0, sr);
        tests++; if (rx_data !== 16'h3C3C) begin fails++; $display("FAIL slow_rx got %h exp 3C3C", rx_data); end
        tests++; if (sr !== 16'hC3C3) begin fails++; $display("FAIL slow_miso got %h exp C3C3", sr); end
    endtask

`ifdef SPI_SLAVE_LOOPBACK_EN
    task automatic test_loopback();
        logic [15:0] sr;
        load_word(16'h5555);
        loopback = 1'b1;
        spi_xfer(16'h1234, 16, 4, 1'b1, 1'b0, 16'h0, sr);
        tests++; if (sr !== 16'h3C3C) begin fails++; $display("FAIL lb_first got %h exp 3C3C", sr); end
        spi_xfer(16'h0F0F, 16, 4, 1'b1, 1'b0, 16'h0, sr);
        tests++; if (sr !== 16'h1234) begin fails++; $display("FAIL lb_second got %h exp 1234", sr); end
        tests++; if (tx_pending !== 1'b1) begin fails++; $display("FAIL lb_pending got %b exp 1", tx_pending); end
        loopback = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_no_load();
        test_frame_err();
        test_load_collision();
        test_reset_mid_frame();
`ifdef SPI_SLAVE_LOOPBACK_EN
        test_loopback();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
